proc_mem_arb: RTL

Arbiter and sequencer that shares one memory port between the TinyRV1 processor's instruction-fetch requester (imem) and load/store requester (dmem). It sits between the processor datapath and the single-ported memory model. It accepts at most one outstanding transaction, drives it onto the memory port with a val/rdy handshake, and routes the memory response back to the requester that issued it. Data requests have priority; a bounded streak counter guarantees fetch progress.

---
 rtl/proc_mem_pkg.sv | 21 ++
 rtl/proc_mem_arb.sv | 122 ++++++++++++
 2 files changed

// File: rtl/proc_mem_pkg.sv
// Shared definitions for the TinyRV1 memory-port arbiter and the processor
// control/datapath that drive dmemreq_type.
package proc_mem_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IMEM,
    OWN_DMEM
  } owner_t;

endpackage

// File: rtl/proc_mem_arb.sv
// Shares one memory port between instruction fetch and load/store, one
// outstanding transaction at a time; data wins unless fetch has waited too long.
module proc_mem_arb
  import proc_mem_pkg::*;
#(
  parameter int MAX_DSTREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        imemreq_val,
  output logic        imemreq_rdy,
  input  logic [31:0] imemreq_addr,
  output logic        imemresp_val,
  output logic [31:0] imemresp_data,

  input  logic        dmemreq_val,
  output logic        dmemreq_rdy,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic        dmemresp_val,
  output logic [31:0] dmemresp_data,

  output logic        memreq_val,
  input  logic        memreq_rdy,
  output logic        memreq_type,
  output logic [31:0] memreq_addr,
  output logic [31:0] memreq_wdata,
  input  logic        memresp_val,
  input  logic [31:0] memresp_data
);

  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_DSTREAK);

  state_t              r_state;
  state_t              w_state_next;
  owner_t              r_owner;
  logic [STREAK_W-1:0] r_streak;
  logic                r_type;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;

  logic w_grant_d;
  logic w_grant_i;
  logic w_resp_fire;

  // Grants are only offered while out of reset so rdy reads 0 during rst_n=0.
  always_comb begin
    w_state_next = r_state;
    w_grant_d    = 1'b0;
    w_grant_i    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (rst_n) begin
          w_grant_d = dmemreq_val && (!imemreq_val || (r_streak < MAX_S));
          w_grant_i = !w_grant_d && imemreq_val;
        end
        if (w_grant_d || w_grant_i) begin
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (memreq_rdy) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (memresp_val) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= OWN_IMEM;
      r_streak <= '0;
      r_type   <= MEM_READ;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_d) begin
        r_owner <= OWN_DMEM;
        r_type  <= dmemreq_type;
        r_addr  <= dmemreq_addr;
        r_wdata <= dmemreq_wdata;
        if (!imemreq_val) begin
          r_streak <= '0;
        end else if (r_streak < MAX_S) begin
          r_streak <= r_streak + 1'b1;
        end
      end else if (w_grant_i) begin
        r_owner  <= OWN_IMEM;
        r_type   <= MEM_READ;
        r_addr   <= imemreq_addr;
        r_wdata  <= '0;
        r_streak <= '0;
      end
    end
  end

  assign imemreq_rdy  = w_grant_i;
  assign dmemreq_rdy  = w_grant_d;

  assign memreq_val   = (r_state == REQ);
  assign memreq_type  = r_type;
  assign memreq_addr  = r_addr;
  assign memreq_wdata = r_wdata;

  // Responses are combinational pass-through; stores return zero data.
  assign w_resp_fire   = (r_state == RESP) && memresp_val;
  assign imemresp_val  = w_resp_fire && (r_owner == OWN_IMEM);
  assign dmemresp_val  = w_resp_fire && (r_owner == OWN_DMEM);
  assign imemresp_data = imemresp_val ? memresp_data : 32'h0;
  assign dmemresp_data = (dmemresp_val && (r_type == MEM_READ)) ? memresp_data : 32'h0;

endmodule
